// File: rtl/pulse_gen_multi_if.sv
// Board-side bundle for pulse_gen_multi: async level inputs and control in,
// registered pulse strobes out.
interface pulse_gen_multi_if #(
    parameter int N_CH = 4
);
    logic [N_CH-1:0] in;
    logic [1:0]      mode;
    logic            en;
    logic [N_CH-1:0] q;
    logic            any;

    modport master (output in, mode, en, input q, any);
    modport slave  (input in, mode, en, output q, any);
endinterface

// File: rtl/pulse_gen_multi.sv
// N-channel synchronising edge-to-pulse generator with optional hold-to-auto-repeat.
// Each channel: sync chain -> edge detect -> non-retriggerable PULSE_W-cycle strobe.
module pulse_gen_multi #(
    parameter int N_CH         = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int PULSE_W      = 1,
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100
) (
    input  logic             clk,
    input  logic             rst_n,
    pulse_gen_multi_if.slave bus
);
    localparam int CNT_W = $clog2(REPEAT_DELAY + 1);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
    localparam logic [CNT_W-1:0] PW_C    = CNT_W'(PULSE_W);
    localparam logic [CNT_W-1:0] DELAY_C = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] RATE_C  = CNT_W'(REPEAT_RATE);

    typedef enum logic [1:0] {IDLE, PULSE, HOLD, REPEAT} state_t;

    state_t                 st   [N_CH];
    logic [CNT_W-1:0]       t    [N_CH];
    logic [CNT_W-1:0]       tinc [N_CH];
    logic [SYNC_STAGES-1:0] sync [N_CH];

    logic [N_CH-1:0] s, h, rise, fall, sel, start, pend, q_nxt, rep;
    logic            auto;

    assign rise = s & ~h;
    assign fall = ~s & h;
    assign auto = (bus.mode == 2'b11);

    always_comb begin
        unique case (bus.mode)
            2'b00:   sel = rise;
            2'b01:   sel = fall;
            2'b10:   sel = rise | fall;
            default: sel = rise;
        endcase
    end

    // start: a pulse begins at the next edge; pend: current pulse has run PULSE_W cycles
    always_comb begin
        s     = '0;
        start = '0;
        pend  = '0;
        q_nxt = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            s[i]    = sync[i][SYNC_STAGES-1];
            tinc[i] = (t[i] == DELAY_C) ? t[i] : t[i] + ONE_C;
            unique case (st[i])
                IDLE:   start[i] = bus.en & sel[i];
                PULSE:  pend[i]  = (t[i] == PW_C);
                HOLD:   start[i] = bus.en & auto & s[i] & (t[i] == DELAY_C);
                REPEAT: start[i] = bus.en & auto & s[i] & (t[i] == RATE_C);
            endcase
            q_nxt[i] = start[i] | (bus.en & (st[i] == PULSE) & ~pend[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                sync[i] <= '0;
                st[i]   <= IDLE;
                t[i]    <= '0;
            end
            h       <= '0;
            rep     <= '0;
            bus.q   <= '0;
            bus.any <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                sync[i] <= {sync[i][SYNC_STAGES-2:0], bus.in[i]};
                if (!bus.en) begin
                    st[i] <= IDLE;
                    t[i]  <= '0;
                end else if (start[i]) begin
                    st[i]  <= PULSE;
                    t[i]   <= ONE_C;
                    rep[i] <= (st[i] != IDLE);
                end else begin
                    unique case (st[i])
                        IDLE: t[i] <= '0;
                        PULSE: begin
                            t[i] <= tinc[i];
                            if (pend[i])
                                st[i] <= !(auto && s[i]) ? IDLE : (rep[i] ? REPEAT : HOLD);
                        end
                        HOLD, REPEAT: begin
                            if (!auto || !s[i]) begin
                                st[i] <= IDLE;
                                t[i]  <= '0;
                            end else begin
                                t[i] <= tinc[i];
                            end
                        end
                    endcase
                end
            end
            h       <= s;
            bus.q   <= q_nxt;
            bus.any <= |q_nxt;
        end
    end
endmodule
